// File: rtl/load_store_unit.sv
// load_store_unit: memory stage of the single-cycle RV32I core.
// Turns one load or store per instruction into a registered req/ack bus
// transaction. It steers byte and halfword lanes, sign- or zero-extends
// load data, and flags misaligned accesses. stall_w_o_h holds the core
// until the access completes.
// Optional feature: define LSU_TIMEOUT_EN to abandon a request that has
// waited TIMEOUT_CYC cycles for ack, and report it on bus_err_w_o_h.
module load_store_unit #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_h,
    input  logic        mem_rd_w_i_h,
    input  logic        mem_wr_w_i_h,
    input  logic [2:0]  funct_3_w_i,
    input  logic [31:0] addr_w_i,
    input  logic [31:0] wr_data_w_i,
    output logic [31:0] ld_data_w_o,
    output logic        stall_w_o_h,
    output logic        misalign_w_o_h,
    output logic        bus_err_w_o_h,
    output logic        bus_req_w_o_h,
    output logic        bus_we_w_o_h,
    output logic [31:0] bus_addr_w_o,
    output logic [31:0] bus_wdata_w_o,
    output logic [3:0]  bus_be_w_o,
    input  logic        bus_ack_w_i_h,
    input  logic [31:0] bus_rdata_w_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        misalign_q, misalign_d;
    logic [2:0]  funct_3_q, funct_3_d;
    logic [1:0]  offset_q, offset_d;

    logic        op_w;
    logic        aligned_w;
    logic [3:0]  lane_be_w;
    logic [31:0] lane_wdata_w;
    logic [15:0] ld_lane_w;
    logic [31:0] ld_ext_w;

`ifdef LSU_TIMEOUT_EN
    logic        bus_err_q, bus_err_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
`else
    logic [7:0]  tmo_cfg_unused;
    assign tmo_cfg_unused = 8'(TIMEOUT_CYC);
`endif

    // A store wins over a load if control raises both; either one is an access.
    assign op_w = mem_wr_w_i_h | mem_rd_w_i_h;

    // Halfwords need an even address and words need a word address; bytes are always aligned.
    always_comb begin
        aligned_w = 1'b1;
        if (funct_3_w_i[1]) begin
            aligned_w = (addr_w_i[1:0] == 2'b00);
        end else if (funct_3_w_i[0]) begin
            aligned_w = ~addr_w_i[0];
        end
    end

    // Replicate store data across all lanes and enable only the lanes the access covers.
    always_comb begin
        lane_be_w    = 4'b1111;
        lane_wdata_w = wr_data_w_i;
        if (!funct_3_w_i[1]) begin
            if (funct_3_w_i[0]) begin
                lane_be_w    = 4'b0011 << addr_w_i[1:0];
                lane_wdata_w = {2{wr_data_w_i[15:0]}};
            end else begin
                lane_be_w    = 4'b0001 << addr_w_i[1:0];
                lane_wdata_w = {4{wr_data_w_i[7:0]}};
            end
        end
    end

    // Shift the addressed bytes of the read word down to bit 0, then extend them to 32 bits.
    always_comb begin
        ld_lane_w = 16'(bus_rdata_w_i >> {offset_q, 3'b000});
        ld_ext_w  = bus_rdata_w_i;
        if (!funct_3_q[1]) begin
            if (funct_3_q[0]) begin
                ld_ext_w = {{16{ld_lane_w[15] & ~funct_3_q[2]}}, ld_lane_w[15:0]};
            end else begin
                ld_ext_w = {{24{ld_lane_w[7] & ~funct_3_q[2]}}, ld_lane_w[7:0]};
            end
        end
    end

    // Next-state and next-output logic; every output is registered except stall.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        ld_data_d   = ld_data_q;
        funct_3_d   = funct_3_q;
        offset_d    = offset_q;
        misalign_d  = 1'b0;
`ifdef LSU_TIMEOUT_EN
        bus_err_d   = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_w) begin
                    funct_3_d = funct_3_w_i;
                    offset_d  = addr_w_i[1:0];
                    if (aligned_w) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_wr_w_i_h;
                        bus_addr_d  = {addr_w_i[31:2], 2'b00};
                        bus_be_d    = lane_be_w;
                        bus_wdata_d = lane_wdata_w;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt_d   = 8'd0;
`endif
                        state_d     = ST_REQ;
                    end else begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus_ack_w_i_h) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        ld_data_d = ld_ext_w;
                    end
                    state_d = ST_DONE;
                end
`ifdef LSU_TIMEOUT_EN
                else if (tmo_cnt_q == 8'(TIMEOUT_CYC - 1)) begin
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk_w_i or posedge res_w_i_h) begin
        if (res_w_i_h) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            bus_be_q    <= 4'd0;
            ld_data_q   <= 32'd0;
            misalign_q  <= 1'b0;
            funct_3_q   <= 3'd0;
            offset_q    <= 2'd0;
`ifdef LSU_TIMEOUT_EN
            bus_err_q   <= 1'b0;
            tmo_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            ld_data_q   <= ld_data_d;
            misalign_q  <= misalign_d;
            funct_3_q   <= funct_3_d;
            offset_q    <= offset_d;
`ifdef LSU_TIMEOUT_EN
            bus_err_q   <= bus_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    // Stall is combinational so the core freezes in the same cycle it presents an access.
    assign stall_w_o_h = ~res_w_i_h &
                         (((state_q == ST_IDLE) & op_w) | (state_q == ST_REQ));

    assign ld_data_w_o    = ld_data_q;
    assign misalign_w_o_h = misalign_q;
    assign bus_req_w_o_h  = bus_req_q;
    assign bus_we_w_o_h   = bus_we_q;
    assign bus_addr_w_o   = bus_addr_q;
    assign bus_wdata_w_o  = bus_wdata_q;
    assign bus_be_w_o     = bus_be_q;
`ifdef LSU_TIMEOUT_EN
    assign bus_err_w_o_h  = bus_err_q;
`else
    assign bus_err_w_o_h  = 1'b0;
`endif

endmodule
